dmem_port_arbiter: RTL and testbench

// - Shares one single-ported unified memory between the fetch stage (read-only) and the memory stage (load/store).
// - Locks the port for multi-cycle reads and buffers one store so the memory stage never waits on a write.
// - Gives loads priority, with a bounded-starvation guarantee for fetch.
// - Sits between fetch/memory stages and the memory model; requesters see the rd_enable/rd_ready handshake they already use.

---
 rtl/dmem_port_arbiter_pkg.sv | 20 ++
 rtl/dmem_port_arbiter_if.sv | 41 ++++
 rtl/dmem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_dmem_port_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared widths, arbiter state encoding and store-buffer payload for the
// unified data/instruction memory port arbiter.
package dmem_port_arbiter_pkg;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned STREAK_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Requester (fetch, memory stage) and memory-side signals of the port arbiter.
interface dmem_port_arbiter_if;
    import dmem_port_arbiter_pkg::*;

    logic [ADDR_W-1:0] i_addr;
    logic              i_rd_enable;
    logic [DATA_W-1:0] i_rd_data;
    logic              i_rd_ready;

    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wr_data;
    logic              d_wr_enable;
    logic              d_wr_ack;
    logic              d_rd_enable;
    logic [DATA_W-1:0] d_rd_data;
    logic              d_rd_ready;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_wr_enable;
    logic              mem_rd_enable;
    logic [DATA_W-1:0] mem_rd_data;
    logic              mem_rd_ready;

    // Arbiter view
    modport slave (
        input  i_addr, i_rd_enable, d_addr, d_wr_data, d_wr_enable, d_rd_enable,
               mem_rd_data, mem_rd_ready,
        output i_rd_data, i_rd_ready, d_wr_ack, d_rd_data, d_rd_ready,
               mem_addr, mem_wr_data, mem_wr_enable, mem_rd_enable
    );

    // Requesters plus memory model view
    modport master (
        output i_addr, i_rd_enable, d_addr, d_wr_data, d_wr_enable, d_rd_enable,
               mem_rd_data, mem_rd_ready,
        input  i_rd_data, i_rd_ready, d_wr_ack, d_rd_data, d_rd_ready,
               mem_addr, mem_wr_data, mem_wr_enable, mem_rd_enable
    );

endinterface

// File: rtl/dmem_port_arbiter.sv
// Single-port memory arbiter: one-entry store buffer, load priority with a
// bounded load streak so a waiting fetch is never starved.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic                clk,
    input  logic                reset,
    dmem_port_arbiter_if.slave  bus
);

    arb_state_e          state_q, state_d;
    wb_entry_t           wb_q;
    logic                wb_valid_q, wb_valid_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                store_take;
    logic                load_gnt;
    logic                fetch_gnt;
    logic                streak_full;

    assign bus.i_rd_data = bus.mem_rd_data;
    assign bus.d_rd_data = bus.mem_rd_data;

    assign streak_full = (streak_q == STREAK_W'(MAX_D_STREAK));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ARB_IDLE;
            wb_valid_q <= 1'b0;
            wb_q       <= '0;
            streak_q   <= '0;
        end else begin
            state_q    <= state_d;
            wb_valid_q <= wb_valid_d;
            streak_q   <= streak_d;
            if (store_take) begin
                wb_q <= '{addr: bus.d_addr, data: bus.d_wr_data};
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        wb_valid_d        = wb_valid_q;
        streak_d          = streak_q;
        load_gnt          = 1'b0;
        fetch_gnt         = 1'b0;
        bus.mem_addr      = '0;
        bus.mem_wr_data   = wb_q.data;
        bus.mem_wr_enable = 1'b0;
        bus.mem_rd_enable = 1'b0;
        bus.i_rd_ready    = 1'b0;
        bus.d_rd_ready    = 1'b0;
        bus.d_wr_ack      = !wb_valid_q;
        // A store entering the buffer this cycle is older than any load beside it
        store_take        = bus.d_wr_enable && !wb_valid_q;

        unique case (state_q)
            ARB_IDLE: begin
                if (wb_valid_q) begin
                    bus.mem_addr      = wb_q.addr;
                    bus.mem_wr_enable = 1'b1;
                    wb_valid_d        = 1'b0;
                end else if (bus.d_rd_enable && !store_take &&
                             !(bus.i_rd_enable && streak_full)) begin
                    load_gnt          = 1'b1;
                    bus.mem_addr      = bus.d_addr;
                    bus.mem_rd_enable = 1'b1;
                    if (bus.mem_rd_ready) bus.d_rd_ready = 1'b1;
                    else                  state_d = ARB_BUSY_D;
                end else if (bus.i_rd_enable) begin
                    fetch_gnt         = 1'b1;
                    bus.mem_addr      = bus.i_addr;
                    bus.mem_rd_enable = 1'b1;
                    if (bus.mem_rd_ready) bus.i_rd_ready = 1'b1;
                    else                  state_d = ARB_BUSY_I;
                end
            end
            ARB_BUSY_D: begin
                if (!bus.d_rd_enable) begin
                    state_d = ARB_IDLE;
                end else begin
                    bus.mem_addr      = bus.d_addr;
                    bus.mem_rd_enable = 1'b1;
                    if (bus.mem_rd_ready) begin
                        bus.d_rd_ready = 1'b1;
                        state_d        = ARB_IDLE;
                    end
                end
            end
            ARB_BUSY_I: begin
                if (!bus.i_rd_enable) begin
                    state_d = ARB_IDLE;
                end else begin
                    bus.mem_addr      = bus.i_addr;
                    bus.mem_rd_enable = 1'b1;
                    if (bus.mem_rd_ready) begin
                        bus.i_rd_ready = 1'b1;
                        state_d        = ARB_IDLE;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        if (store_take) wb_valid_d = 1'b1;

        // Streak counts load grants only while a fetch is waiting
        if (!bus.i_rd_enable || fetch_gnt) begin
            streak_d = '0;
        end else if (load_gnt && !streak_full) begin
            streak_d = streak_q + STREAK_W'(1);
        end

        if (!reset) begin
            bus.mem_wr_enable = 1'b0;
            bus.mem_rd_enable = 1'b0;
            bus.i_rd_ready    = 1'b0;
            bus.d_rd_ready    = 1'b0;
            bus.d_wr_ack      = 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus a randomized run scored
// against an architectural memory and simple ordering/starvation rules.
module tb_dmem_port_arbiter;

    localparam int unsigned MAX_D = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_port_arbiter_if bus();

    dmem_port_arbiter #(.MAX_D_STREAK(MAX_D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Memory model: latency per read transaction, writes land at the clock edge
    logic [31:0] mem_a  [logic [31:0]];
    logic [31:0] arch_a [logic [31:0]];
    int wait_cnt = 0;
    int lat = 0;
    int fixed_lat = 0;
    bit force_ready = 1'b0;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    function logic [31:0] mem_read(input logic [31:0] a);
        return mem_a.exists(a) ? mem_a[a] : init_val(a);
    endfunction

    function logic [31:0] arch_read(input logic [31:0] a);
        return arch_a.exists(a) ? arch_a[a] : init_val(a);
    endfunction

    task automatic mem_respond();
        if (bus.mem_rd_enable && wait_cnt >= lat) begin
            bus.mem_rd_ready = 1'b1;
            bus.mem_rd_data  = mem_read(bus.mem_addr);
        end else begin
            bus.mem_rd_ready = force_ready;
            bus.mem_rd_data  = $urandom;
        end
    endtask

    task automatic settle();
        #1;
        mem_respond();
        #1;
    endtask

    task automatic advance();
        if (bus.mem_wr_enable) mem_a[bus.mem_addr] = bus.mem_wr_data;
        if (bus.mem_rd_enable && !bus.mem_rd_ready) begin
            wait_cnt++;
        end else begin
            wait_cnt = 0;
            lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
        end
        @(negedge clk);
    endtask

    task automatic clear_req();
        bus.i_addr      = '0;
        bus.i_rd_enable = 1'b0;
        bus.d_addr      = '0;
        bus.d_wr_data   = '0;
        bus.d_wr_enable = 1'b0;
        bus.d_rd_enable = 1'b0;
    endtask

    task automatic idle_cycle();
        clear_req();
        settle();
        advance();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.i_rd_enable = 1'b1; bus.i_addr = 32'h100;
        bus.d_rd_enable = 1'b1; bus.d_addr = 32'h200;
        bus.d_wr_enable = 1'b1; bus.d_wr_data = 32'h1;
        settle();
        checks++;
        if ({bus.mem_wr_enable, bus.mem_rd_enable, bus.i_rd_ready, bus.d_rd_ready, bus.d_wr_ack} !== 5'b0)
            begin errors++; $display("FAIL reset_outputs: got %b want 00000",
                {bus.mem_wr_enable, bus.mem_rd_enable, bus.i_rd_ready, bus.d_rd_ready, bus.d_wr_ack}); end
        advance();
        advance();
        reset = 1'b1;
        clear_req();
        settle();
        checks++;
        if ({bus.mem_wr_enable, bus.mem_rd_enable, bus.d_wr_ack} !== 3'b001)
            begin errors++; $display("FAIL post_reset_idle: wr/rd/ack got %b want 001",
                {bus.mem_wr_enable, bus.mem_rd_enable, bus.d_wr_ack}); end
        advance();
    endtask

    task automatic test_fetch_only();
        int en_cnt = 0;
        int rdy_cnt = 0;
        int rdy_cyc = -1;
        bit hold = 1'b1;
        fixed_lat = 2; lat = 2; wait_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            clear_req();
            bus.i_addr = 32'h100;
            bus.i_rd_enable = hold;
            settle();
            if (bus.mem_rd_enable) en_cnt++;
            if (bus.i_rd_ready) begin
                rdy_cnt++;
                rdy_cyc = c;
                hold = 1'b0;
                checks++;
                if (bus.i_rd_data !== init_val(32'h100))
                    begin errors++; $display("FAIL fetch_data: got %h want %h", bus.i_rd_data, init_val(32'h100)); end
            end
            advance();
        end
        checks++;
        if (en_cnt != 3) begin errors++; $display("FAIL fetch_rd_enable_cycles: got %0d want 3", en_cnt); end
        checks++;
        if (rdy_cnt != 1) begin errors++; $display("FAIL fetch_ready_pulses: got %0d want 1", rdy_cnt); end
        checks++;
        if (rdy_cyc != 2) begin errors++; $display("FAIL fetch_ready_cycle: got %0d want 2", rdy_cyc); end
    endtask

    task automatic test_load_vs_fetch();
        bit d_hold = 1'b1;
        bit i_hold = 1'b1;
        int d_cyc = -1;
        int i_cyc = -1;
        fixed_lat = 0; lat = 0;
        for (int c = 0; c < 4; c++) begin
            clear_req();
            bus.d_addr = 32'h300; bus.d_rd_enable = d_hold;
            bus.i_addr = 32'h104; bus.i_rd_enable = i_hold;
            settle();
            if (bus.d_rd_ready) begin
                d_cyc = c; d_hold = 1'b0;
                checks++;
                if (bus.d_rd_data !== init_val(32'h300))
                    begin errors++; $display("FAIL lvf_load_data: got %h want %h", bus.d_rd_data, init_val(32'h300)); end
            end
            if (bus.i_rd_ready) begin
                i_cyc = c; i_hold = 1'b0;
                checks++;
                if (bus.i_rd_data !== init_val(32'h104))
                    begin errors++; $display("FAIL lvf_fetch_data: got %h want %h", bus.i_rd_data, init_val(32'h104)); end
            end
            advance();
        end
        checks++;
        if (d_cyc != 0 || i_cyc != 1)
            begin errors++; $display("FAIL lvf_order: load at %0d fetch at %0d want 0 and 1", d_cyc, i_cyc); end
    endtask

    task automatic test_starvation();
        bit exp_d;
        fixed_lat = 0; lat = 0;
        idle_cycle();
        for (int c = 0; c < 20; c++) begin
            clear_req();
            bus.d_addr = 32'h304; bus.d_rd_enable = 1'b1;
            bus.i_addr = 32'h108; bus.i_rd_enable = 1'b1;
            settle();
            exp_d = (c % 5) != 4;
            checks++;
            if (bus.d_rd_ready !== exp_d || bus.i_rd_ready !== !exp_d)
                begin errors++; $display("FAIL starve_c%0d: d/i ready got %b%b want %b%b", c,
                    bus.d_rd_ready, bus.i_rd_ready, exp_d, !exp_d); end
            advance();
        end
        idle_cycle();
    endtask

    task automatic test_store_load();
        fixed_lat = 0; lat = 0;
        clear_req();
        bus.d_addr = 32'h200; bus.d_wr_data = 32'hDEADBEEF; bus.d_wr_enable = 1'b1;
        settle();
        checks++;
        if (bus.d_wr_ack !== 1'b1) begin errors++; $display("FAIL st_ack: got %b want 1", bus.d_wr_ack); end
        advance();
        clear_req();
        bus.d_addr = 32'h200; bus.d_rd_enable = 1'b1;
        settle();
        checks++;
        if ({bus.mem_wr_enable, bus.mem_rd_enable, bus.d_rd_ready} !== 3'b100 ||
            bus.mem_addr !== 32'h200 || bus.mem_wr_data !== 32'hDEADBEEF)
            begin errors++; $display("FAIL st_drain: wr/rd/rdy %b addr %h data %h want 100 200 deadbeef",
                {bus.mem_wr_enable, bus.mem_rd_enable, bus.d_rd_ready}, bus.mem_addr, bus.mem_wr_data); end
        advance();
        settle();
        checks++;
        if (bus.d_rd_ready !== 1'b1 || bus.d_rd_data !== 32'hDEADBEEF)
            begin errors++; $display("FAIL st_load: ready %b data %h want 1 deadbeef", bus.d_rd_ready, bus.d_rd_data); end
        advance();
        // Store and load together: store buffered, load served after the drain
        clear_req();
        bus.d_addr = 32'h204; bus.d_wr_data = 32'hCAFEF00D;
        bus.d_wr_enable = 1'b1; bus.d_rd_enable = 1'b1;
        settle();
        checks++;
        if ({bus.d_wr_ack, bus.mem_rd_enable, bus.d_rd_ready} !== 3'b100)
            begin errors++; $display("FAIL simul_first: ack/rd/rdy got %b want 100",
                {bus.d_wr_ack, bus.mem_rd_enable, bus.d_rd_ready}); end
        advance();
        bus.d_wr_enable = 1'b0;
        settle();
        checks++;
        if (bus.mem_wr_enable !== 1'b1 || bus.d_rd_ready !== 1'b0)
            begin errors++; $display("FAIL simul_drain: wr %b rdy %b want 1 0", bus.mem_wr_enable, bus.d_rd_ready); end
        advance();
        settle();
        checks++;
        if (bus.d_rd_ready !== 1'b1 || bus.d_rd_data !== 32'hCAFEF00D)
            begin errors++; $display("FAIL simul_load: ready %b data %h want 1 cafef00d", bus.d_rd_ready, bus.d_rd_data); end
        advance();
        idle_cycle();
    endtask

    task automatic test_flush();
        fixed_lat = 5; lat = 5;
        for (int c = 0; c < 2; c++) begin
            clear_req();
            bus.i_addr = 32'h10C; bus.i_rd_enable = 1'b1;
            settle();
            advance();
        end
        clear_req();
        fixed_lat = 0;
        settle();
        checks++;
        if (bus.mem_rd_enable !== 1'b0 || bus.i_rd_ready !== 1'b0)
            begin errors++; $display("FAIL flush_cycle: rd_en %b ready %b want 0 0", bus.mem_rd_enable, bus.i_rd_ready); end
        advance();
        bus.d_addr = 32'h308; bus.d_rd_enable = 1'b1;
        settle();
        checks++;
        if (bus.d_rd_ready !== 1'b1 || bus.i_rd_ready !== 1'b0 || bus.mem_addr !== 32'h308)
            begin errors++; $display("FAIL flush_idle: d/i ready %b%b addr %h want 10 308",
                bus.d_rd_ready, bus.i_rd_ready, bus.mem_addr); end
        advance();
        idle_cycle();
    endtask

    task automatic test_reset_mid();
        fixed_lat = 5; lat = 5;
        clear_req();
        bus.d_addr = 32'h210; bus.d_rd_enable = 1'b1;
        settle();
        advance();
        bus.d_wr_enable = 1'b1; bus.d_wr_data = 32'h12345678; bus.d_addr = 32'h210;
        settle();
        checks++;
        if (bus.d_wr_ack !== 1'b1 || bus.mem_rd_enable !== 1'b1)
            begin errors++; $display("FAIL rmid_ack: ack %b rd_en %b want 1 1", bus.d_wr_ack, bus.mem_rd_enable); end
        advance();
        bus.d_wr_enable = 1'b0;
        reset = 1'b0;
        settle();
        checks++;
        if ({bus.mem_wr_enable, bus.mem_rd_enable, bus.i_rd_ready, bus.d_rd_ready, bus.d_wr_ack} !== 5'b0)
            begin errors++; $display("FAIL rmid_outputs: got %b want 00000",
                {bus.mem_wr_enable, bus.mem_rd_enable, bus.i_rd_ready, bus.d_rd_ready, bus.d_wr_ack}); end
        advance();
        reset = 1'b1;
        clear_req();
        force_ready = 1'b1;
        fixed_lat = 0;
        settle();
        checks++;
        if ({bus.mem_wr_enable, bus.mem_rd_enable, bus.i_rd_ready, bus.d_rd_ready, bus.d_wr_ack} !== 5'b00001)
            begin errors++; $display("FAIL rmid_after: wr/rd/ir/dr/ack got %b want 00001",
                {bus.mem_wr_enable, bus.mem_rd_enable, bus.i_rd_ready, bus.d_rd_ready, bus.d_wr_ack}); end
        advance();
        force_ready = 1'b0;
        bus.i_addr = 32'h110; bus.i_rd_enable = 1'b1;
        settle();
        checks++;
        if (bus.i_rd_ready !== 1'b1 || bus.i_rd_data !== init_val(32'h110))
            begin errors++; $display("FAIL rmid_clean_grant: ready %b data %h want 1 %h",
                bus.i_rd_ready, bus.i_rd_data, init_val(32'h110)); end
        advance();
        checks++;
        if (mem_read(32'h210) !== init_val(32'h210))
            begin errors++; $display("FAIL rmid_store_dropped: mem %h want %h", mem_read(32'h210), init_val(32'h210)); end
        idle_cycle();
    endtask

    task automatic test_random();
        bit f_act = 0, l_act = 0, s_act = 0;
        logic [31:0] f_addr = '0, l_addr = '0, s_addr = '0, s_data = '0;
        int f_age = 0, l_age = 0, f_starve = 0;
        bit l_was;
        mem_a.delete();
        arch_a.delete();
        fixed_lat = -1;
        for (int c = 0; c < 1500; c++) begin
            l_was = l_act;
            if (!f_act && ($urandom % 3) == 0) begin
                f_act = 1; f_age = 0; f_starve = 0;
                f_addr = 32'h1000 + 32'($urandom_range(0, 63)) * 4;
            end else if (f_act && ($urandom % 40) == 0) begin
                f_act = 0;
            end
            if (!l_act && ($urandom % 3) == 0) begin
                l_act = 1; l_age = 0;
                l_addr = 32'h200 + 32'($urandom_range(0, 7)) * 4;
            end else if (l_act && ($urandom % 40) == 0) begin
                l_act = 0;
            end
            // Memory stage is in order: no new store behind an outstanding load
            if (!s_act && !l_was && ($urandom % 4) == 0) begin
                s_act = 1;
                s_addr = 32'h200 + 32'($urandom_range(0, 7)) * 4;
                s_data = $urandom;
            end
            bus.i_addr = f_addr; bus.i_rd_enable = f_act;
            bus.d_addr = s_act ? s_addr : l_addr;
            bus.d_rd_enable = l_act;
            bus.d_wr_enable = s_act; bus.d_wr_data = s_data;
            // Load and store share d_addr; only overlap them when addresses agree
            if (s_act && l_act && s_addr != l_addr) bus.d_rd_enable = 1'b0;
            settle();
            checks++;
            if (bus.mem_wr_enable && bus.mem_rd_enable)
                begin errors++; $display("FAIL rnd_wr_rd_overlap c%0d: wr %b rd %b want not both", c,
                    bus.mem_wr_enable, bus.mem_rd_enable); end
            if (bus.i_rd_ready) begin
                checks++;
                if (!f_act || bus.i_rd_data !== init_val(f_addr))
                    begin errors++; $display("FAIL rnd_fetch c%0d: act %b data %h want 1 %h", c,
                        f_act, bus.i_rd_data, init_val(f_addr)); end
                f_act = 0;
            end
            if (bus.d_rd_ready) begin
                checks++;
                if (!bus.d_rd_enable || bus.d_rd_data !== arch_read(l_addr))
                    begin errors++; $display("FAIL rnd_load c%0d: en %b data %h want 1 %h", c,
                        bus.d_rd_enable, bus.d_rd_data, arch_read(l_addr)); end
                l_act = 0;
                if (f_act) begin
                    f_starve++;
                    checks++;
                    if (f_starve > int'(MAX_D) + 1)
                        begin errors++; $display("FAIL rnd_starve c%0d: loads while fetch waits %0d want <= %0d",
                            c, f_starve, MAX_D + 1); end
                end
            end
            if (bus.d_wr_ack && s_act) begin
                arch_a[s_addr] = s_data;
                s_act = 0;
            end
            f_age++; l_age++;
            if ((f_act && f_age > 200) || (l_act && l_age > 200)) begin
                errors++; checks++;
                $display("FAIL rnd_timeout c%0d: fetch age %0d load age %0d want <= 200", c, f_age, l_age);
                f_act = 0; l_act = 0;
            end
            advance();
        end
        idle_cycle();
        idle_cycle();
    endtask

    initial begin
        reset = 1'b0;
        clear_req();
        bus.mem_rd_ready = 1'b0;
        bus.mem_rd_data  = '0;
        @(negedge clk);
        test_reset();
        test_fetch_only();
        idle_cycle();
        test_load_vs_fetch();
        idle_cycle();
        test_starvation();
        test_store_load();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
